// File: rtl/mux_arbiter_2x1.sv
// Two-requester valid/ready arbiter feeding one registered output slot.
// Round-robin or fixed-priority ties; one word per cycle when the consumer keeps up.
module mux_arbiter_2x1 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i0_valid,
  input  logic [DATA_W-1:0] i0_data,
  output logic              i0_ready,
  input  logic              i1_valid,
  input  logic [DATA_W-1:0] i1_data,
  output logic              i1_ready,
  input  logic              fixed_pri,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_src,
  output logic              sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                   state;
  logic                     sel_q;
  logic                     last_src;
  logic                     load_en;
  logic                     xfer;
  logic [1:0]               req;
  logic [1:0][DATA_W-1:0]   dat;

  assign req = {i1_valid, i0_valid};
  assign dat = {i1_data, i0_data};

  always_comb begin
    sel = sel_q;
    unique case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = fixed_pri ? 1'b0 : ~last_src;
      default: sel = sel_q;
    endcase
  end

  // Whenever any request is up, sel points at a valid requester.
  assign load_en   = ((state == EMPTY) || out_ready) && rst_n;
  assign xfer      = load_en && (|req);
  assign i0_ready  = load_en && req[0] && !sel;
  assign i1_ready  = load_en && req[1] &&  sel;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= 1'b0;
      sel_q    <= 1'b0;
      last_src <= 1'b1;
    end else begin
      sel_q <= sel;
      if (xfer) begin
        out_data <= dat[sel];
        out_src  <= sel;
        last_src <= sel;
      end
      unique case (state)
        EMPTY: if (xfer) state <= FULL;
        FULL:  if (out_ready && !xfer) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/mux_arbiter_2x1.md
MUX_ARBITER_2X1 -- requirements
Module: mux_arbiter_2x1

Interface
REQ-001 Parameter: DATA_W, default 32, width of every data path.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i0_valid  input  1  requester 0 has a word on i0_data.
REQ-005 i0_data  input  DATA_W  requester 0 word.
REQ-006 i0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 i1_valid  input  1  requester 1 has a word on i1_data.
REQ-008 i1_data  input  DATA_W  requester 1 word.
REQ-009 i1_ready  output  1  requester 1 word accepted this cycle.
REQ-010 fixed_pri  input  1  1 = requester 0 always wins a tie; 0 = round-robin.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 out_data  output  DATA_W  registered selected word.
REQ-013 out_ready  input  1  consumer takes out_data this cycle.
REQ-014 out_src  output  1  source of the current out_data: 0 = i0, 1 = i1.
REQ-015 sel  output  1  combinational mux select for this cycle's grant: 0 = i0, 1 = i1.

Function
REQ-016 Handshake: a transfer occurs on any edge where valid and ready are both 1; senders hold data stable while valid=1 and ready=0.
REQ-017 load_en = (!out_valid || out_ready) && rst_n; a new word is accepted only when load_en=1.
REQ-018 Grant, one input valid: that input is granted.
REQ-019 Grant, both valid and fixed_pri=1: i0 is granted.
REQ-020 Grant, both valid and fixed_pri=0: the input other than last_src is granted.
REQ-021 No input valid: no grant; sel holds its previous registered value.
REQ-022 ix_ready = load_en && grant_x; at most one ready is high per cycle; ready never depends on ix_valid of the other port beyond REQ-018..020.
REQ-023 On a transfer: out_data <= granted data (via sel), out_src <= sel, last_src <= sel, out_valid <= 1; latency input-to-output is exactly 1 cycle.
REQ-024 out_valid=1 and out_ready=0: out_data, out_src, out_valid hold; both readies 0.
REQ-025 out_valid=1, out_ready=1, an input valid: consume and reload in the same edge, giving back-to-back throughput of 1 word/cycle.
REQ-026 out_valid=1, out_ready=1, no input valid: out_valid <= 0; out_data and out_src hold their last values.
REQ-027 last_src updates only on a transfer, in either fixed_pri mode; toggling fixed_pri mid-stream takes effect on the next grant decision with no lost or duplicated word.
REQ-028 out_ready while out_valid=0 has no effect.
REQ-029 States: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on a grant. FULL->EMPTY on out_ready with no grant. FULL->FULL on hold, or on consume-plus-reload.

Reset
REQ-030 While rst_n=0 at an edge: out_valid<=0, out_data<=0, out_src<=0, sel register<=0, last_src<=1 (so i0 wins the first tie).
REQ-031 While rst_n=0, i0_ready=i1_ready=0 combinationally.
REQ-032 Reset asserted mid-transfer discards any held word; the word is not delivered.
REQ-033 First grant is possible on the first edge after rst_n returns to 1.

Verification
REQ-034 After reset, both valid, i0_data=0xAAAA0000, i1_data=0x5555FFFF, fixed_pri=0, out_ready=1 -> i0 accepted first, then i1, alternating. Outputs 0xAAAA0000/src0, 0x5555FFFF/src1, ... one per cycle.
REQ-035 Same stimulus with fixed_pri=1 -> only i0 accepted every cycle; i1_ready stays 0.
REQ-036 i1 only valid with 0x12345678, out_ready=0 for 3 cycles -> one accept; out_data=0x12345678, out_src=1 held for 3 cycles; i1_ready=0 during the hold; released when out_ready=1.
REQ-037 Single word, then inputs idle, out_ready=1 -> out_valid high exactly 1 cycle, then 0; out_data keeps its value.
REQ-038 rst_n driven low while FULL with 0xDEADBEEF -> next edge out_valid=0, out_data=0, readies 0; after release, a tie grants i0.
REQ-039 Random valid/ready/fixed_pri for 10k cycles against a scoreboard -> no loss, duplication or reorder per source, and never two readies high in one cycle.
